// File: rtl/pattern_det_ctrl_if.sv
// Configuration, control, serial-data and status signals of the pattern detector.
// The master side drives configuration and data; the slave side is the detector itself.
interface pattern_det_ctrl_if #(
    parameter int PW = 8,
    parameter int CW = 4
);
    localparam int LW = (PW > 1) ? $clog2(PW) : 1;

    logic          cfg_valid;
    logic          cfg_ready;
    logic [PW-1:0] cfg_pattern;
    logic [LW-1:0] cfg_len;
    logic          cfg_overlap;
    logic [CW-1:0] cfg_target;
    logic          start;
    logic          stop;
    logic          in;
    logic          in_valid;
    logic          out;
    logic [CW-1:0] match_cnt;
    logic          busy;
    logic          done;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        output start, stop, in, in_valid,
        input  cfg_ready, out, match_cnt, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
        input  start, stop, in, in_valid,
        output cfg_ready, out, match_cnt, busy, done
    );
endinterface

// File: rtl/pattern_det_ctrl.sv
// Serial bit-pattern detector with IDLE/RUN/DONE control, overlap/non-overlap
// matching, saturating match counter and optional match-count target.
module pattern_det_ctrl #(
    parameter int PW = 8,
    parameter int CW = 4
) (
    input  logic              clk,
    input  logic              rst,
    pattern_det_ctrl_if.slave bus
);
    localparam int LW = (PW > 1) ? $clog2(PW) : 1;
    localparam int FW = $clog2(PW + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_next;

    logic [PW-1:0] pattern_q;
    logic [LW-1:0] len_q;
    logic          overlap_q;
    logic [CW-1:0] target_q;

    logic [PW-1:0] hist_q;
    logic [FW-1:0] fill_q;
    logic [CW-1:0] cnt_q;
    logic          out_q;

    logic [FW-1:0] need;
    logic [PW-1:0] mask;
    logic [PW-1:0] hist_shift;
    logic [FW-1:0] fill_inc;
    logic [CW-1:0] cnt_inc;
    logic          hit;

    logic          cfg_load;
    logic          clear;
    logic          sample;
    logic          match;

    // Candidate post-shift history and fill count, used to decide a match on this edge.
    always_comb begin
        need       = FW'(len_q) + FW'(1);
        hist_shift = (hist_q << 1) | PW'(bus.in);
        fill_inc   = (fill_q >= need) ? fill_q : fill_q + FW'(1);
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
        mask       = '0;
        for (int i = 0; i < PW; i++) begin
            mask[i] = (i <= int'(len_q));
        end
        hit = (fill_inc >= need) && (((hist_shift ^ pattern_q) & mask) == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: all clocked state uses non-blocking assignments so every register
            // samples pre-edge values and simulation order cannot change the result.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that left
        // one unassigned would infer a latch.
        state_next = state;
        cfg_load   = 1'b0;
        clear      = 1'b0;
        sample     = 1'b0;
        match      = 1'b0;
        unique case (state)
            IDLE: begin
                cfg_load = bus.cfg_valid;
                if (bus.start && !bus.stop) begin
                    state_next = RUN;
                    clear      = 1'b1;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    state_next = IDLE;
                end else if (bus.in_valid) begin
                    sample = 1'b1;
                    match  = hit;
                    if (hit && (target_q != '0) && (cnt_inc == target_q)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.stop) begin
                    state_next = IDLE;
                end else if (bus.start) begin
                    state_next = RUN;
                    clear      = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_q <= '0;
            len_q     <= '0;
            overlap_q <= 1'b0;
            target_q  <= '0;
            hist_q    <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            out_q     <= 1'b0;
        end else begin
            out_q <= match;
            if (cfg_load) begin
                pattern_q <= bus.cfg_pattern;
                len_q     <= bus.cfg_len;
                overlap_q <= bus.cfg_overlap;
                target_q  <= bus.cfg_target;
            end
            if (clear) begin
                hist_q <= '0;
                fill_q <= '0;
                cnt_q  <= '0;
            end else if (sample) begin
                hist_q <= hist_shift;
                // Non-overlapping mode demands a full set of fresh bits after each match.
                fill_q <= (match && !overlap_q) ? '0 : fill_inc;
                if (match) begin
                    cnt_q <= cnt_inc;
                end
            end
        end
    end

    assign bus.cfg_ready = (state == IDLE);
    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.out       = out_q;
    assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Directed bench for pattern_det_ctrl; each task drives one scenario and checks
// outputs one time unit after the active clock edge.
module tb_pattern_det_ctrl;
    localparam int PW = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pattern_det_ctrl_if #(.PW(PW), .CW(CW)) bus ();

    pattern_det_ctrl #(.PW(PW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, required to finish earlier", $time);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cfg_valid   = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_len     = '0;
        bus.cfg_overlap = 1'b0;
        bus.cfg_target  = '0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.in          = 1'b0;
        bus.in_valid    = 1'b0;
    endtask

    task automatic cfg_start(input logic [PW-1:0] p, input logic [2:0] l,
                             input logic ov, input logic [CW-1:0] t);
        bus.cfg_valid   = 1'b1;
        bus.cfg_pattern = p;
        bus.cfg_len     = l;
        bus.cfg_overlap = ov;
        bus.cfg_target  = t;
        bus.start       = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
        bus.start     = 1'b0;
    endtask

    task automatic feed(input logic b, input logic v);
        bus.in       = b;
        bus.in_valid = v;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic stop_run();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        n_vec += 5;
        if (bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL reset_cfg_ready: got %b expected 1", bus.cfg_ready); end
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        if (bus.out !== 1'b0) begin n_err++; $display("FAIL reset_out: got %b expected 0", bus.out); end
        if (bus.match_cnt !== 4'd0) begin n_err++; $display("FAIL reset_match_cnt: got %0d expected 0", bus.match_cnt); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_vec++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_release_busy: got %b expected 0", bus.busy); end
    endtask

    task automatic test_overlap();
        logic [4:0] bits = 5'b10101;
        logic [4:0] eo   = 5'b00101;
        int         ec[5] = '{0, 0, 1, 1, 2};
        cfg_start(8'b101, 3'd2, 1'b1, 4'd0);
        n_vec += 2;
        if (bus.busy !== 1'b1) begin n_err++; $display("FAIL ovl_busy: got %b expected 1", bus.busy); end
        if (bus.cfg_ready !== 1'b0) begin n_err++; $display("FAIL ovl_cfg_ready: got %b expected 0", bus.cfg_ready); end
        for (int i = 0; i < 5; i++) begin
            feed(bits[4-i], 1'b1);
            n_vec += 2;
            if (bus.out !== eo[4-i]) begin n_err++; $display("FAIL ovl_out bit %0d: got %b expected %b", i, bus.out, eo[4-i]); end
            if (int'(bus.match_cnt) != ec[i]) begin n_err++; $display("FAIL ovl_cnt bit %0d: got %0d expected %0d", i, bus.match_cnt, ec[i]); end
        end
        // start and a config write while running must change nothing
        bus.start       = 1'b1;
        bus.cfg_valid   = 1'b1;
        bus.cfg_pattern = 8'h00;
        tick();
        bus.start     = 1'b0;
        bus.cfg_valid = 1'b0;
        n_vec += 2;
        if (bus.busy !== 1'b1) begin n_err++; $display("FAIL ovl_start_ignored_busy: got %b expected 1", bus.busy); end
        if (bus.match_cnt !== 4'd2) begin n_err++; $display("FAIL ovl_start_ignored_cnt: got %0d expected 2", bus.match_cnt); end
        feed(1'b0, 1'b1);
        feed(1'b1, 1'b1);
        n_vec += 2;
        if (bus.out !== 1'b1) begin n_err++; $display("FAIL ovl_cfg_ignored_out: got %b expected 1", bus.out); end
        if (bus.match_cnt !== 4'd3) begin n_err++; $display("FAIL ovl_cfg_ignored_cnt: got %0d expected 3", bus.match_cnt); end
        stop_run();
        n_vec += 3;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL ovl_stop_busy: got %b expected 0", bus.busy); end
        if (bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL ovl_stop_cfg_ready: got %b expected 1", bus.cfg_ready); end
        if (bus.match_cnt !== 4'd3) begin n_err++; $display("FAIL ovl_stop_cnt_hold: got %0d expected 3", bus.match_cnt); end
    endtask

    task automatic test_non_overlap();
        logic [4:0] bits = 5'b10101;
        logic [4:0] eo   = 5'b00100;
        int         ec[5] = '{0, 0, 1, 1, 1};
        cfg_start(8'b101, 3'd2, 1'b0, 4'd0);
        for (int i = 0; i < 5; i++) begin
            feed(bits[4-i], 1'b1);
            n_vec += 2;
            if (bus.out !== eo[4-i]) begin n_err++; $display("FAIL novl_out bit %0d: got %b expected %b", i, bus.out, eo[4-i]); end
            if (int'(bus.match_cnt) != ec[i]) begin n_err++; $display("FAIL novl_cnt bit %0d: got %0d expected %0d", i, bus.match_cnt, ec[i]); end
        end
        stop_run();
    endtask

    task automatic test_target();
        // upper pattern bits are junk and must be ignored for a 1-bit pattern
        cfg_start(8'hAB, 3'd0, 1'b1, 4'd3);
        for (int i = 0; i < 3; i++) begin
            feed(1'b1, 1'b1);
            n_vec += 3;
            if (bus.out !== 1'b1) begin n_err++; $display("FAIL tgt_out bit %0d: got %b expected 1", i, bus.out); end
            if (int'(bus.match_cnt) != i + 1) begin n_err++; $display("FAIL tgt_cnt bit %0d: got %0d expected %0d", i, bus.match_cnt, i + 1); end
            if (bus.done !== (i == 2)) begin n_err++; $display("FAIL tgt_done bit %0d: got %b expected %b", i, bus.done, (i == 2)); end
        end
        n_vec++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL tgt_busy_in_done: got %b expected 0", bus.busy); end
        feed(1'b1, 1'b1);
        n_vec += 3;
        if (bus.out !== 1'b0) begin n_err++; $display("FAIL tgt_4th_out: got %b expected 0", bus.out); end
        if (bus.match_cnt !== 4'd3) begin n_err++; $display("FAIL tgt_4th_cnt: got %0d expected 3", bus.match_cnt); end
        if (bus.done !== 1'b1) begin n_err++; $display("FAIL tgt_4th_done: got %b expected 1", bus.done); end
        bus.cfg_valid   = 1'b1;
        bus.cfg_pattern = 8'h00;
        #1;
        n_vec++;
        if (bus.cfg_ready !== 1'b0) begin n_err++; $display("FAIL tgt_done_cfg_ready: got %b expected 0", bus.cfg_ready); end
        tick();
        bus.cfg_valid = 1'b0;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        n_vec += 3;
        if (bus.busy !== 1'b1) begin n_err++; $display("FAIL tgt_restart_busy: got %b expected 1", bus.busy); end
        if (bus.done !== 1'b0) begin n_err++; $display("FAIL tgt_restart_done: got %b expected 0", bus.done); end
        if (bus.match_cnt !== 4'd0) begin n_err++; $display("FAIL tgt_restart_cnt: got %0d expected 0", bus.match_cnt); end
        feed(1'b1, 1'b1);
        n_vec++;
        if (bus.out !== 1'b1) begin n_err++; $display("FAIL tgt_restart_out: got %b expected 1", bus.out); end
        stop_run();
    endtask

    task automatic test_gaps();
        logic [5:0] bits = 6'b110011;
        logic [5:0] vld  = 6'b101001;
        cfg_start(8'b101, 3'd2, 1'b1, 4'd0);
        for (int i = 0; i < 6; i++) begin
            feed(bits[5-i], vld[5-i]);
            n_vec++;
            if (bus.out !== (i == 5)) begin n_err++; $display("FAIL gap_out step %0d: got %b expected %b", i, bus.out, (i == 5)); end
        end
        n_vec++;
        if (bus.match_cnt !== 4'd1) begin n_err++; $display("FAIL gap_cnt: got %0d expected 1", bus.match_cnt); end
        stop_run();
    endtask

    task automatic test_stop_on_match();
        cfg_start(8'b101, 3'd2, 1'b1, 4'd1);
        feed(1'b1, 1'b1);
        feed(1'b0, 1'b1);
        bus.in       = 1'b1;
        bus.in_valid = 1'b1;
        bus.stop     = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.stop     = 1'b0;
        n_vec += 5;
        if (bus.out !== 1'b0) begin n_err++; $display("FAIL stop_out: got %b expected 0", bus.out); end
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_err++; $display("FAIL stop_done: got %b expected 0", bus.done); end
        if (bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL stop_cfg_ready: got %b expected 1", bus.cfg_ready); end
        if (bus.match_cnt !== 4'd0) begin n_err++; $display("FAIL stop_cnt: got %0d expected 0", bus.match_cnt); end
        tick();
        n_vec++;
        if (bus.out !== 1'b0) begin n_err++; $display("FAIL stop_late_out: got %b expected 0", bus.out); end
    endtask

    task automatic test_rst_mid();
        cfg_start(8'b101, 3'd2, 1'b1, 4'd0);
        feed(1'b1, 1'b1);
        feed(1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        n_vec += 2;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
        if (bus.cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_cfg_ready: got %b expected 1", bus.cfg_ready); end
        tick();
        rst = 1'b0;
        feed(1'b1, 1'b1);
        n_vec += 2;
        if (bus.out !== 1'b0) begin n_err++; $display("FAIL rst_idle_out: got %b expected 0", bus.out); end
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_idle_busy: got %b expected 0", bus.busy); end
        // restart without a config write: reset config is a 1-bit pattern of 0
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        feed(1'b1, 1'b1);
        n_vec++;
        if (bus.out !== 1'b0) begin n_err++; $display("FAIL rst_remaining_out: got %b expected 0", bus.out); end
        feed(1'b0, 1'b1);
        n_vec += 2;
        if (bus.out !== 1'b1) begin n_err++; $display("FAIL rst_cfg_default_out: got %b expected 1", bus.out); end
        if (bus.match_cnt !== 4'd1) begin n_err++; $display("FAIL rst_cfg_default_cnt: got %0d expected 1", bus.match_cnt); end
        stop_run();
    endtask

    task automatic test_saturate();
        cfg_start(8'b1, 3'd0, 1'b1, 4'd0);
        for (int i = 0; i < 17; i++) begin
            feed(1'b1, 1'b1);
            n_vec++;
            if (int'(bus.match_cnt) != ((i + 1 > 15) ? 15 : i + 1)) begin
                n_err++;
                $display("FAIL sat_cnt bit %0d: got %0d expected %0d", i, bus.match_cnt, (i + 1 > 15) ? 15 : i + 1);
            end
        end
        n_vec++;
        if (bus.out !== 1'b1) begin n_err++; $display("FAIL sat_out: got %b expected 1", bus.out); end
        stop_run();
    endtask

    task automatic test_back_to_back();
        logic [2:0] eo = 3'b011;
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_stop_beats_start: got busy %b expected 0", bus.busy); end
        cfg_start(8'b11, 3'd1, 1'b1, 4'd2);
        for (int i = 0; i < 3; i++) begin
            feed(1'b1, 1'b1);
            n_vec += 2;
            if (bus.out !== eo[2-i]) begin n_err++; $display("FAIL b2b_out bit %0d: got %b expected %b", i, bus.out, eo[2-i]); end
            if (bus.done !== (i == 2)) begin n_err++; $display("FAIL b2b_done bit %0d: got %b expected %b", i, bus.done, (i == 2)); end
        end
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        n_vec += 3;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL b2b_done_stop_busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0) begin n_err++; $display("FAIL b2b_done_stop_done: got %b expected 0", bus.done); end
        if (bus.match_cnt !== 4'd2) begin n_err++; $display("FAIL b2b_done_stop_cnt: got %0d expected 2", bus.match_cnt); end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_target();
        test_gaps();
        test_stop_on_match();
        test_rst_mid();
        test_saturate();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
